// File: rtl/pattern_encoder_pkg.sv
// Packet layout and FSM encodings shared by the pattern encoder and its matching packet decoder.
package pattern_encoder_pkg;

    localparam int PKT_DATA_BIT = 32;
    localparam int PKT_PACK_NUM = 1 + 2 * PKT_DATA_BIT / 8;

    localparam int CMD_START_BIT = 0;
    localparam int CMD_STOP_BIT  = 1;
    localparam int CMD_MODE_BIT  = 2;
    localparam int CMD_SEL_LSB   = 4;
    localparam int CMD_SEL_MSB   = 7;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SEND = 3'd1,
        S_WAIT = 3'd2,
        S_GAP  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    function automatic logic [7:0] pack_cmd_byte(input logic [3:0] sel,
                                                 input logic       start,
                                                 input logic       stop,
                                                 input logic       mode);
        logic [7:0] b;
        b = '0;
        b[CMD_SEL_MSB:CMD_SEL_LSB] = sel;
        b[CMD_START_BIT]           = start;
        b[CMD_STOP_BIT]            = stop;
        b[CMD_MODE_BIT]            = mode;
        return b;
    endfunction

endpackage

// File: rtl/pattern_encoder.sv
// Packs one channel command into a PACK_NUM-byte packet and streams it, byte 0 first,
// to a UART transmitter through a start / done-tick handshake.
module pattern_encoder
    import pattern_encoder_pkg::*;
#(
    parameter int DATA_BIT = PKT_DATA_BIT,
    parameter int PACK_NUM = PKT_PACK_NUM,
    parameter int TX_GAP   = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_load,
    input  logic [DATA_BIT-1:0] i_output_pattern,
    input  logic [DATA_BIT-1:0] i_freq_pattern,
    input  logic [3:0]          i_sel_out,
    input  logic                i_cmd_start,
    input  logic                i_cmd_stop,
    input  logic                i_cmd_mode,
    input  logic                i_tx_done_tick,
    output logic [7:0]          o_tx_data,
    output logic                o_tx_start,
    output logic                o_busy,
    output logic                o_done_tick
);

    localparam int SHIFT_W = PACK_NUM * 8;
    localparam int CNT_W   = (PACK_NUM > 1) ? $clog2(PACK_NUM) : 1;
    localparam int GAP_W   = (TX_GAP > 1) ? $clog2(TX_GAP) : 1;
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(PACK_NUM - 1);
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'((TX_GAP > 0) ? TX_GAP - 1 : 0);

    state_t             state;
    logic [CNT_W-1:0]   byte_cnt;
    logic [GAP_W-1:0]   gap_cnt;
    logic [SHIFT_W-1:0] shift_reg;
    logic               accept;
    logic               last_byte;
    logic               advance;

    assign accept    = (state == S_IDLE) && i_load;
    assign last_byte = (byte_cnt == LAST_BYTE);
    assign advance   = (state == S_WAIT) && i_tx_done_tick && !last_byte;

    // Packet payload only; its contents are meaningless until the FSM has accepted a load.
    always_ff @(posedge clk) begin
        if (accept) begin
            shift_reg <= {pack_cmd_byte(i_sel_out, i_cmd_start, i_cmd_stop, i_cmd_mode),
                          i_output_pattern, i_freq_pattern};
        end else if (advance) begin
            shift_reg <= {shift_reg[SHIFT_W-9:0], 8'h00};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            byte_cnt    <= '0;
            gap_cnt     <= '0;
            o_tx_data   <= 8'h00;
            o_tx_start  <= 1'b0;
            o_busy      <= 1'b0;
            o_done_tick <= 1'b0;
        end else begin
            o_tx_start  <= 1'b0;
            o_done_tick <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_load) begin
                        byte_cnt <= '0;
                        gap_cnt  <= '0;
                        o_busy   <= 1'b1;
                        state    <= S_SEND;
                    end
                end
                S_SEND: begin
                    o_tx_data  <= shift_reg[SHIFT_W-1 -: 8];
                    o_tx_start <= 1'b1;
                    state      <= S_WAIT;
                end
                S_WAIT: begin
                    // The done tick is registered straight into o_done_tick so that S_DONE
                    // is the single cycle in which the pulse is visible and loads are refused.
                    if (i_tx_done_tick) begin
                        if (last_byte) begin
                            o_done_tick <= 1'b1;
                            o_busy      <= 1'b0;
                            state       <= S_DONE;
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                            gap_cnt  <= '0;
                            state    <= (TX_GAP == 0) ? S_SEND : S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= S_SEND;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pattern_encoder.sv
// Directed bench for pattern_encoder: one instance without inter-byte gap, one with TX_GAP=4.
module tb_pattern_encoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        load_a, start_a, stop_a, mode_a;
    logic [31:0] out_a, freq_a;
    logic [3:0]  sel_a;
    logic        mdone_a = 1'b0;
    logic        done_in_a;
    logic [7:0]  tx_data_a;
    logic        tx_start_a, busy_a, done_tick_a;

    logic        load_b, start_b, stop_b, mode_b;
    logic [31:0] out_b, freq_b;
    logic [3:0]  sel_b;
    logic        mdone_b = 1'b0;
    logic        spur_b;
    logic        done_in_b;
    logic [7:0]  tx_data_b;
    logic        tx_start_b, busy_b, done_tick_b;

    assign done_in_a = mdone_a;
    assign done_in_b = mdone_b | spur_b;

    pattern_encoder #(.DATA_BIT(32), .PACK_NUM(9), .TX_GAP(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .i_load(load_a),
        .i_output_pattern(out_a), .i_freq_pattern(freq_a), .i_sel_out(sel_a),
        .i_cmd_start(start_a), .i_cmd_stop(stop_a), .i_cmd_mode(mode_a),
        .i_tx_done_tick(done_in_a),
        .o_tx_data(tx_data_a), .o_tx_start(tx_start_a), .o_busy(busy_a), .o_done_tick(done_tick_a)
    );

    pattern_encoder #(.DATA_BIT(32), .PACK_NUM(9), .TX_GAP(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .i_load(load_b),
        .i_output_pattern(out_b), .i_freq_pattern(freq_b), .i_sel_out(sel_b),
        .i_cmd_start(start_b), .i_cmd_stop(stop_b), .i_cmd_mode(mode_b),
        .i_tx_done_tick(done_in_b),
        .o_tx_data(tx_data_b), .o_tx_start(tx_start_b), .o_busy(busy_b), .o_done_tick(done_tick_b)
    );

    // UART TX models: answer each o_tx_start with a done tick 10 cycles later and log the stream.
    logic [7:0] q_a[$];
    int         gaps_a[$];
    int         dtk_a = 0, last_done_a = 0, cnt_a = 0;
    bit         has_done_a = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            cnt_a = 0; mdone_a = 1'b0; has_done_a = 0;
        end else begin
            mdone_a = 1'b0;
            if (done_tick_a) begin dtk_a++; has_done_a = 0; end
            if (cnt_a > 0) begin
                cnt_a--;
                if (cnt_a == 0) begin mdone_a = 1'b1; last_done_a = cyc + 1; has_done_a = 1; end
            end
            if (tx_start_a) begin
                q_a.push_back(tx_data_a);
                cnt_a = 10;
                if (has_done_a) gaps_a.push_back(cyc - last_done_a - 1);
            end
        end
    end

    logic [7:0] q_b[$];
    int         gaps_b[$];
    int         dtk_b = 0, last_done_b = 0, cnt_b = 0;
    bit         has_done_b = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            cnt_b = 0; mdone_b = 1'b0; has_done_b = 0;
        end else begin
            mdone_b = 1'b0;
            if (done_tick_b) begin dtk_b++; has_done_b = 0; end
            if (cnt_b > 0) begin
                cnt_b--;
                if (cnt_b == 0) begin mdone_b = 1'b1; last_done_b = cyc + 1; has_done_b = 1; end
            end
            if (tx_start_b) begin
                q_b.push_back(tx_data_b);
                cnt_b = 10;
                if (has_done_b) gaps_b.push_back(cyc - last_done_b - 1);
            end
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic chk_stream(input string tag, input logic [7:0] q[$], input int base,
                              input logic [7:0] exp[9]);
        chk({tag, "_len"}, 64'(q.size() - base), 64'd9);
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("%s_b%0d", tag, i),
                (base + i < q.size()) ? {1'b0, q[base+i]} : 9'h100, {1'b0, exp[i]});
        end
    endtask

    // Independent reassembly of the fields the downstream packet decoder would recover.
    task automatic decode_chk(input string tag, input logic [7:0] q[$], input int base,
                              input logic [31:0] eo, input logic [31:0] ef, input logic [3:0] es,
                              input logic est, input logic esp, input logic emd);
        logic [7:0] b[9];
        for (int i = 0; i < 9; i++) b[i] = (base + i < q.size()) ? q[base+i] : 8'h00;
        chk({tag, "_sel"},   b[0][7:4], es);
        chk({tag, "_start"}, b[0][0], est);
        chk({tag, "_stop"},  b[0][1], esp);
        chk({tag, "_mode"},  b[0][2], emd);
        chk({tag, "_out"},   {b[1], b[2], b[3], b[4]}, eo);
        chk({tag, "_freq"},  {b[5], b[6], b[7], b[8]}, ef);
    endtask

    task automatic gaps_chk(input string tag, input int g[$], input int base, input int exp_gap);
        chk({tag, "_count"}, 64'(g.size() - base), 64'd8);
        for (int i = base; i < g.size(); i++)
            chk($sformatf("%s_%0d", tag, i - base), 64'(g[i]), 64'(exp_gap));
    endtask

    int load_cyc_a = 0;

    task automatic load_a_t(input logic [31:0] o, input logic [31:0] f, input logic [3:0] s,
                            input logic st, input logic sp, input logic md);
        @(negedge clk);
        out_a = o; freq_a = f; sel_a = s; start_a = st; stop_a = sp; mode_a = md; load_a = 1'b1;
        @(negedge clk);
        load_a = 1'b0;
        load_cyc_a = cyc;
    endtask

    task automatic load_b_t(input logic [31:0] o, input logic [31:0] f, input logic [3:0] s,
                            input logic st, input logic sp, input logic md);
        @(negedge clk);
        out_b = o; freq_b = f; sel_b = s; start_b = st; stop_b = sp; mode_b = md; load_b = 1'b1;
        @(negedge clk);
        load_b = 1'b0;
    endtask

    logic [7:0] exp1[9] = '{8'h05, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h00, 8'hFF, 8'hFF};
    logic [7:0] exp2[9] = '{8'h33, 8'hCA, 8'hFE, 8'hF0, 8'h0D, 8'h0F, 8'h0F, 8'h0F, 8'h0F};
    logic [7:0] exp3[9] = '{8'hB2, 8'hA5, 8'hC3, 8'h0F, 8'h96, 8'h12, 8'h34, 8'h80, 8'h01};

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "global timeout");
    end

    initial begin
        int base, dbase, gbase, n;

        rst_n = 1'b0;
        load_a = 0; out_a = '0; freq_a = '0; sel_a = '0; start_a = 0; stop_a = 0; mode_a = 0;
        load_b = 0; out_b = '0; freq_b = '0; sel_b = '0; start_b = 0; stop_b = 0; mode_b = 0;
        spur_b = 0;
        repeat (3) @(negedge clk);
        chk("rst_tx_data", tx_data_a, 8'h00);
        chk("rst_tx_start", tx_start_a, 1'b0);
        chk("rst_busy", busy_a, 1'b0);
        chk("rst_done", done_tick_a, 1'b0);
        chk("rst_busy_b", busy_b, 1'b0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic packet, plus a load presented in the same cycle as o_done_tick
        base = q_a.size(); dbase = dtk_a; gbase = gaps_a.size();
        load_a_t(32'hDEADBEEF, 32'h0000FFFF, 4'd0, 1'b1, 1'b0, 1'b1);
        chk("busy_after_load", busy_a, 1'b1);
        n = 0;
        while (tx_start_a !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        chk("start_latency", 64'(cyc - load_cyc_a), 64'd1);
        n = 0;
        while (done_tick_a !== 1'b1 && n < 300) begin @(negedge clk); n++; end
        chk("done_tick_seen", done_tick_a, 1'b1);
        chk("done_align", 64'(cyc), 64'(last_done_a));
        chk("busy_falls_with_done", busy_a, 1'b0);
        out_a = 32'h12345678; load_a = 1'b1;
        @(negedge clk);
        load_a = 1'b0;
        repeat (6) @(negedge clk);
        chk("load_on_done_busy", busy_a, 1'b0);
        chk("done_count_basic", 64'(dtk_a - dbase), 64'd1);
        chk_stream("basic", q_a, base, exp1);
        gaps_chk("gap0", gaps_a, gbase, 0);
        decode_chk("loop_basic", q_a, base, 32'hDEADBEEF, 32'h0000FFFF, 4'd0, 1'b1, 1'b0, 1'b1);

        // Load while busy must be ignored
        base = q_a.size(); dbase = dtk_a;
        load_a_t(32'hCAFEF00D, 32'h0F0F0F0F, 4'd3, 1'b1, 1'b1, 1'b0);
        n = 0;
        while (q_a.size() - base < 3 && n < 100) begin @(negedge clk); n++; end
        load_a_t(32'h12345678, 32'h87654321, 4'd9, 1'b0, 1'b0, 1'b1);
        n = 0;
        while (dtk_a == dbase && n < 300) begin @(negedge clk); n++; end
        repeat (30) @(negedge clk);
        chk("done_count_busy", 64'(dtk_a - dbase), 64'd1);
        chk_stream("busy_rej", q_a, base, exp2);
        decode_chk("loop_busy", q_a, base, 32'hCAFEF00D, 32'h0F0F0F0F, 4'd3, 1'b1, 1'b1, 1'b0);

        // Spurious done in idle, then a gapped packet with a spurious done inside S_GAP
        base = q_b.size(); dbase = dtk_b; gbase = gaps_b.size();
        @(negedge clk); spur_b = 1'b1;
        @(negedge clk); spur_b = 1'b0;
        repeat (5) @(negedge clk);
        chk("spur_idle_busy", busy_b, 1'b0);
        chk("spur_idle_bytes", 64'(q_b.size() - base), 64'd0);
        load_b_t(32'hA5C30F96, 32'h12348001, 4'hB, 1'b0, 1'b1, 1'b0);
        n = 0;
        while (mdone_b !== 1'b1 && n < 50) begin @(posedge clk); n++; end
        @(negedge clk); spur_b = 1'b1;
        @(negedge clk); spur_b = 1'b0;
        n = 0;
        while (dtk_b == dbase && n < 400) begin @(negedge clk); n++; end
        repeat (10) @(negedge clk);
        chk("done_count_gap", 64'(dtk_b - dbase), 64'd1);
        chk_stream("gap", q_b, base, exp3);
        gaps_chk("gap4", gaps_b, gbase, 4);
        decode_chk("loop_gap", q_b, base, 32'hA5C30F96, 32'h12348001, 4'hB, 1'b0, 1'b1, 1'b0);

        // Reset in the middle of a packet
        base = q_a.size(); dbase = dtk_a;
        load_a_t(32'hDEADBEEF, 32'h0000FFFF, 4'd0, 1'b1, 1'b0, 1'b1);
        n = 0;
        while (q_a.size() - base < 4 && n < 100) begin @(negedge clk); n++; end
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_tx_data", tx_data_a, 8'h00);
        chk("midrst_tx_start", tx_start_a, 1'b0);
        chk("midrst_busy", busy_a, 1'b0);
        chk("midrst_done", done_tick_a, 1'b0);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("midrst_no_done", 64'(dtk_a - dbase), 64'd0);
        chk("midrst_no_bytes", 64'(q_a.size() - base), 64'd4);
        chk("midrst_idle", busy_a, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
